// File: rtl/cache_types.sv
// Shared cache-side types: adapter FSM states and default burst geometry.
package cache_types;

  localparam int LINE_W        = 256;
  localparam int LINE_OFF_W    = $clog2(LINE_W / 8);
  localparam int DEF_BEAT_W    = 64;
  localparam int DEF_BURST_LEN = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_WAIT  = 3'd2,
    WR_BURST = 3'd3,
    RESP     = 3'd4,
    DONE     = 3'd5
  } adapter_state_e;

endpackage

// File: rtl/cacheline_adapter.sv
// Bridges 256-bit cacheline read/write requests onto a beat-wide burst memory port.
module cacheline_adapter
  import cache_types::*;
#(
  parameter int BEAT_W    = DEF_BEAT_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  generate
    if (BEAT_W * BURST_LEN != LINE_W) begin : g_bad_geometry
      $error("cacheline_adapter: BEAT_W*BURST_LEN must equal %0d", LINE_W);
    end
  endgenerate

  adapter_state_e    state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [LINE_W-1:0] line_reg;
  logic [LINE_W-1:0] line_next;
  logic              last_beat;
  logic              unused_bits;

  // Returning read tags and the in-line byte offset carry no information here.
  assign unused_bits = ^{bmem_raddr, dfp_addr[LINE_OFF_W-1:0]};
  assign last_beat   = (cnt_reg == LAST_BEAT);

  always_comb begin
    line_next = line_reg;
    line_next[int'(cnt_reg)*BEAT_W +: BEAT_W] = bmem_rdata;
  end

  assign bmem_read  = (state_reg == RD_REQ);
  assign bmem_write = (state_reg == WR_BURST);
  assign dfp_resp   = (state_reg == RESP);
  assign bmem_wdata = bmem_write ? dfp_wdata[int'(cnt_reg)*BEAT_W +: BEAT_W] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      line_reg  <= '0;
      dfp_rdata <= '0;
      bmem_addr <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (dfp_write || dfp_read) begin
            cnt_reg   <= '0;
            bmem_addr <= {dfp_addr[31:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
            state_reg <= dfp_write ? WR_BURST : RD_REQ;
          end
        end
        RD_REQ: begin
          if (bmem_ready) begin
            cnt_reg   <= '0;
            state_reg <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bmem_rvalid) begin
            line_reg <= line_next;
            if (last_beat) begin
              // Publish the whole line at once so dfp_rdata never shows a partial fill.
              dfp_rdata <= line_next;
              cnt_reg   <= '0;
              state_reg <= RESP;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (bmem_ready) begin
            if (last_beat) begin
              cnt_reg   <= '0;
              state_reg <= RESP;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        RESP:    state_reg <= DONE;
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized bench for cacheline_adapter with a transaction-level memory and line model.
module tb_cacheline_adapter;

  localparam int BEAT_W = 64;
  localparam int BURSTS = 4;

  logic         clk;
  logic         rst_n;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int n_checks;
  int n_errors;
  logic [255:0] model_rdata;

  cacheline_adapter #(.BEAT_W(BEAT_W), .BURST_LEN(BURSTS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cacheline transaction; the bench plays the burst memory cycle by cycle.
  task automatic run_txn(input string name, input logic [31:0] addr, input bit rd, input bit wr,
                         input logic [255:0] wline, input logic [255:0] rline,
                         input int ready_pct, input int stall_beat, input int gap_after1,
                         input int max_gap, input bit spurious, input bit hold_extra,
                         input int abort_beats, input int exp_lat);
    int cyc, resp_cyc, resp_cnt, rd_acc, after_cmd, both_hi, held_bad;
    int wr_idx, stall_left, rd_idx, wait_cnt, abort_cyc;
    bit rd_active, seen_resp, aborted, addr_seen;
    logic [31:0]  seen_addr;
    logic [255:0] got_line;
    logic [63:0]  got_beats [BURSTS];
    cyc = 0; resp_cyc = -1; resp_cnt = 0; rd_acc = 0; after_cmd = 0; both_hi = 0;
    held_bad = 0; wr_idx = 0; stall_left = 2; rd_idx = 0; wait_cnt = 0; abort_cyc = 0;
    rd_active = 0; seen_resp = 0; aborted = 0; addr_seen = 0;
    seen_addr = '0; got_line = '0;
    for (int b = 0; b < BURSTS; b++) got_beats[b] = '0;

    dfp_addr  = addr;
    dfp_read  = rd;
    dfp_write = wr;
    dfp_wdata = wline;

    for (int k = 0; k < 300; k++) begin
      if (abort_beats > 0 && !aborted && rd_idx >= abort_beats) begin
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_bmem_read", bmem_read, 1'b0);
        chk("abort_bmem_write", bmem_write, 1'b0);
        chk("abort_resp", dfp_resp, 1'b0);
        chk("abort_bmem_addr", bmem_addr, 32'h0);
        chk("abort_bmem_wdata", bmem_wdata, 64'h0);
        chk("abort_rdata", dfp_rdata, 256'h0);
        aborted   = 1;
        abort_cyc = cyc;
        model_rdata = '0;
      end
      if (aborted && cyc == abort_cyc + 2) rst_n = 1'b1;

      // Read-data channel for this cycle.
      bmem_rvalid = 1'b0;
      bmem_rdata  = {$urandom, $urandom};
      if (rd_active) begin
        if (wait_cnt > 0) begin
          wait_cnt--;
        end else begin
          bmem_rvalid = 1'b1;
          bmem_rdata  = rline[rd_idx*BEAT_W +: BEAT_W];
          rd_idx++;
          wait_cnt = (rd_idx == 2 && gap_after1 >= 0) ? gap_after1 : $urandom_range(max_gap, 0);
          if (rd_idx == BURSTS) rd_active = 0;
        end
      end else if (spurious && $urandom_range(1, 0) == 1) begin
        bmem_rvalid = 1'b1;
      end

      bmem_ready = ($urandom_range(99, 0) < ready_pct);
      if (bmem_write && wr_idx == stall_beat && stall_left > 0) begin
        bmem_ready = 1'b0;
        stall_left--;
      end

      if (bmem_read && bmem_write) both_hi++;
      if ((bmem_read || bmem_write) && !addr_seen) begin
        seen_addr = bmem_addr;
        addr_seen = 1;
      end
      if (seen_resp && (bmem_read || bmem_write)) after_cmd++;
      if (bmem_read && bmem_ready) begin
        rd_acc++;
        rd_active = 1;
        rd_idx    = 0;
        wait_cnt  = (exp_lat >= 0) ? 0 : $urandom_range(2, 0);
      end
      if (bmem_write && wr_idx < BURSTS) begin
        if (bmem_ready) begin
          got_beats[wr_idx] = bmem_wdata;
          wr_idx++;
        end else if (bmem_wdata !== wline[wr_idx*BEAT_W +: BEAT_W]) begin
          held_bad++;
        end
      end
      if (dfp_resp) begin
        resp_cnt++;
        if (!seen_resp) begin
          seen_resp = 1;
          resp_cyc  = cyc;
          got_line  = dfp_rdata;
        end
      end
      if (seen_resp && cyc == resp_cyc + (hold_extra ? 2 : 1)) begin
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
      end

      if (aborted ? (cyc >= abort_cyc + 12) : (seen_resp && cyc >= resp_cyc + 4)) break;
      @(posedge clk);
      #1;
      cyc++;
    end

    dfp_read    = 1'b0;
    dfp_write   = 1'b0;
    bmem_rvalid = 1'b0;
    bmem_ready  = 1'b0;

    if (abort_beats > 0) begin
      chk("abort_no_resp", resp_cnt, 0);
      chk("abort_rdata_after", dfp_rdata, 256'h0);
    end else begin
      chk("resp_count", resp_cnt, 1);
      chk("line_addr", seen_addr, {addr[31:5], 5'b0});
      chk("rd_wr_overlap", both_hi, 0);
      chk("cmd_after_resp", after_cmd, 0);
      if (wr) begin
        chk("wr_no_read", rd_acc, 0);
        chk("wr_beat_count", wr_idx, BURSTS);
        for (int b = 0; b < BURSTS; b++)
          chk($sformatf("wr_beat%0d", b), got_beats[b], wline[b*BEAT_W +: BEAT_W]);
        chk("wr_beat_held", held_bad, 0);
        chk("wr_rdata_unchanged", got_line, model_rdata);
      end else begin
        chk("rd_accept_count", rd_acc, 1);
        chk("rd_line", got_line, rline);
        model_rdata = rline;
      end
      chk("rdata_hold", dfp_rdata, model_rdata);
      if (exp_lat >= 0) chk("latency", resp_cyc, exp_lat);
    end
    $display("txn %-10s addr=%08h rd=%0d wr=%0d resp_cycle=%0d aborted=%0d",
             name, addr, rd, wr, resp_cyc, aborted);
  endtask

  logic [255:0] wl;
  logic [255:0] rl;
  int op;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    model_rdata = '0;
    rst_n       = 1'b0;
    dfp_addr    = '0;
    dfp_read    = 1'b0;
    dfp_write   = 1'b0;
    dfp_wdata   = '0;
    bmem_ready  = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    bmem_rvalid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_resp", dfp_resp, 1'b0);
    chk("reset_bmem_read", bmem_read, 1'b0);
    chk("reset_bmem_write", bmem_write, 1'b0);
    chk("reset_bmem_addr", bmem_addr, 32'h0);
    chk("reset_bmem_wdata", bmem_wdata, 64'h0);
    chk("reset_rdata", dfp_rdata, 256'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    rl = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    run_txn("rd_b2b", 32'h0000_1234, 1, 0, '0, rl, 100, -1, -1, 0, 0, 0, 0, 6);

    wl = {64'hDDDD_0003_DDDD_0003, 64'hCCCC_0002_CCCC_0002,
          64'hBBBB_0001_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
    run_txn("wr_stall", 32'h8000_00E0, 0, 1, wl, '0, 100, 2, -1, 0, 0, 0, 0, 7);

    wl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_txn("rd_and_wr", 32'h0000_4444, 1, 1, wl, '0, 100, -1, -1, 0, 0, 0, 0, 5);

    rl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_txn("rd_gap", 32'h1234_5678, 1, 0, '0, rl, 100, -1, 3, 0, 1, 0, 0, -1);

    rl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_txn("rd_hold", 32'h0000_0040, 1, 0, '0, rl, 100, -1, -1, 1, 0, 1, 0, -1);

    rl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_txn("rd_abort", 32'h0000_0BEE, 1, 0, '0, rl, 100, -1, -1, 0, 0, 0, 2, -1);

    rl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_txn("rd_post_rst", 32'h0000_0C00, 1, 0, '0, rl, 100, -1, -1, 0, 0, 0, 0, 6);

    for (int t = 0; t < 24; t++) begin
      wl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      op = $urandom_range(2, 0);
      run_txn($sformatf("rand%0d", t), $urandom, (op != 1), (op != 0), wl, rl,
              $urandom_range(100, 30), -1, -1, $urandom_range(3, 0),
              bit'($urandom_range(1, 0)), bit'($urandom_range(1, 0)), 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
